// File: rtl/wsat_pkg.sv
// wsat_pkg: shared constants and types for the SAT variable table
package wsat_pkg;
  localparam int NUM_VARS = 2048;
  localparam int VAR_ADDR_W = $clog2(NUM_VARS);
  typedef enum logic {CLEAR, RUN} state_t;
  typedef struct packed {
    logic [VAR_ADDR_W-1:0] addr;
    logic neg;
  } lit_t;
endpackage

// File: rtl/var_table_server_if.sv
// var_table_server_if: evaluator-side variable read, flip-write and load bus
interface var_table_server_if #(parameter int ADDR_W = wsat_pkg::VAR_ADDR_W);
  logic read1, read2, neg_bit1, neg_bit2;
  logic [ADDR_W-1:0] var_address1, var_address2;
  logic rd_valid1, rd_valid2, lit_value1, lit_value2;
  logic write, flip_value;
  logic [ADDR_W-1:0] flip_var_address;
  logic load_valid, load_ready, load_value;
  logic [ADDR_W-1:0] load_address;
  logic ready, addr_err;
  logic [31:0] flip_count;
  modport master (
    output read1, var_address1, neg_bit1, read2, var_address2, neg_bit2,
    output write, flip_var_address, flip_value, load_valid, load_address, load_value,
    input rd_valid1, rd_valid2, lit_value1, lit_value2, load_ready, ready, addr_err, flip_count
  );
  modport slave (
    input read1, var_address1, neg_bit1, read2, var_address2, neg_bit2,
    input write, flip_var_address, flip_value, load_valid, load_address, load_value,
    output rd_valid1, rd_valid2, lit_value1, lit_value2, load_ready, ready, addr_err, flip_count
  );
endinterface

// File: rtl/var_table_server_ram.sv
// var_table_ram: 1-bit-wide table, two synchronous read ports, one write port, no bypass
module var_table_ram #(
  parameter int DEPTH = 2048,
  parameter int AW = 11
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic wdata,
  input logic re1,
  input logic [AW-1:0] ra1,
  input logic re2,
  input logic [AW-1:0] ra2,
  output logic rd1,
  output logic rd2
);
  logic mem [DEPTH];
  // single write port
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // two independent read ports, old data on same-edge collision
  always_ff @(posedge clk) begin
    if (re1) rd1 <= mem[ra1];
    if (re2) rd2 <= mem[ra2];
  end
endmodule

// File: rtl/var_table_server.sv
// var_table_server: variable truth table with dual literal reads, flip writes and bulk load
// Optional macro WSAT_FLIP_COUNT_EN enables the saturating flip_count counter.
module var_table_server
  import wsat_pkg::*;
(
  input logic clk,
  input logic rst,
  var_table_server_if.slave bus
);
  state_t state, state_nx;
  logic [VAR_ADDR_W-1:0] ptr, waddr;
  logic run, flip_ok, load_ok, we, wdata;
  logic valid1, valid2, neg1, neg2, hit1, hit2, hit_val, ram1, ram2;
  lit_t req1, req2;
  assign run = state == RUN;
  assign req1 = '{addr: bus.var_address1, neg: bus.neg_bit1};
  assign req2 = '{addr: bus.var_address2, neg: bus.neg_bit2};
  assign flip_ok = run && bus.write && bus.flip_var_address != '0;
  assign load_ok = bus.load_valid && bus.load_ready && bus.load_address != '0;
  // state register and clear sweep pointer
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      ptr <= '0;
    end else begin
      state <= state_nx;
      ptr <= run ? ptr : ptr + 1'b1;
    end
  // leave CLEAR once the last entry is swept; only rst leaves RUN
  always_comb state_nx = (!run && ptr == VAR_ADDR_W'(NUM_VARS - 1)) ? RUN : state;
  // status outputs and write-port mux: sweep zeros in CLEAR, flip beats load in RUN
  always_comb begin
    bus.ready = run;
    bus.load_ready = run && !bus.write;
    we = !run || flip_ok || load_ok;
    waddr = !run ? ptr : flip_ok ? bus.flip_var_address : bus.load_address;
    wdata = run && (flip_ok ? bus.flip_value : bus.load_value);
  end
  // capture neg bits and same-cycle write hits alongside the RAM read
  always_ff @(posedge clk)
    if (rst) begin
      {valid1, valid2, neg1, neg2, hit1, hit2, hit_val} <= '0;
    end else begin
      valid1 <= run && bus.read1;
      valid2 <= run && bus.read2;
      neg1 <= req1.neg;
      neg2 <= req2.neg;
      hit1 <= run && we && waddr == req1.addr;
      hit2 <= run && we && waddr == req2.addr;
      hit_val <= wdata;
    end
  assign bus.rd_valid1 = valid1;
  assign bus.rd_valid2 = valid2;
  assign bus.lit_value1 = valid1 && ((hit1 ? hit_val : ram1) ^ neg1);
  assign bus.lit_value2 = valid2 && ((hit2 ? hit_val : ram2) ^ neg2);
  // sticky flag for any RUN-state access to reserved address 0
  always_ff @(posedge clk)
    if (rst) bus.addr_err <= 1'b0;
    else if (run && ((bus.read1 && bus.var_address1 == '0) || (bus.read2 && bus.var_address2 == '0) ||
             (bus.write && bus.flip_var_address == '0) ||
             (bus.load_valid && bus.load_ready && bus.load_address == '0)))
      bus.addr_err <= 1'b1;
`ifdef WSAT_FLIP_COUNT_EN
  // saturating count of accepted flip writes to real variables
  always_ff @(posedge clk)
    if (rst) bus.flip_count <= '0;
    else if (flip_ok && bus.flip_count != '1) bus.flip_count <= bus.flip_count + 1'b1;
`else
  assign bus.flip_count = '0;
`endif
  var_table_ram #(.DEPTH(NUM_VARS), .AW(VAR_ADDR_W)) ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .re1(run && bus.read1),
    .ra1(req1.addr),
    .re2(run && bus.read2),
    .ra2(req2.addr),
    .rd1(ram1),
    .rd2(ram2)
  );
endmodule

// File: tb/tb_var_table_server.sv
// tb_var_table_server: directed vectors, model-checked random traffic and reset corners
module tb_var_table_server;
  import wsat_pkg::*;
`ifdef WSAT_FLIP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct {
    int r1, a1, n1, r2, a2, n2, w, fa, fv, lv, la, ld;
    int x_lr, x_v1, x_l1, x_v2, x_l2;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  bit mem_m [NUM_VARS];
  bit err_m;
  logic [31:0] fc_m;
  vec_t vecs [13];
  var_table_server_if bus();
  var_table_server dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int r1, a1, n1, r2, a2, n2, w, fa, fv, lv, la, ld);
    bus.read1 = r1[0]; bus.var_address1 = VAR_ADDR_W'(a1); bus.neg_bit1 = n1[0];
    bus.read2 = r2[0]; bus.var_address2 = VAR_ADDR_W'(a2); bus.neg_bit2 = n2[0];
    bus.write = w[0]; bus.flip_var_address = VAR_ADDR_W'(fa); bus.flip_value = fv[0];
    bus.load_valid = lv[0]; bus.load_address = VAR_ADDR_W'(la); bus.load_value = ld[0];
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = 1'b0;
    err_m = 1'b0;
    fc_m = '0;
  endtask

  // apply the spec rules to the inputs currently driven: writes land first, reads see them
  task automatic model_step(output logic e1, output logic e2);
    logic load_acc;
    load_acc = bus.load_valid && !bus.write;
    if (bus.write) begin
      if (bus.flip_var_address != 0) begin
        mem_m[bus.flip_var_address] = bus.flip_value;
        if (fc_m != 32'hFFFF_FFFF) fc_m = fc_m + 1;
      end else err_m = 1'b1;
    end
    if (load_acc) begin
      if (bus.load_address != 0) mem_m[bus.load_address] = bus.load_value;
      else err_m = 1'b1;
    end
    if (bus.read1 && bus.var_address1 == 0) err_m = 1'b1;
    if (bus.read2 && bus.var_address2 == 0) err_m = 1'b1;
    e1 = mem_m[bus.var_address1] ^ bus.neg_bit1;
    e2 = mem_m[bus.var_address2] ^ bus.neg_bit2;
  endtask

  task automatic run_cycle(output logic lr, v1, l1, v2, l2, e1, e2);
    #1 lr = bus.load_ready;
    model_step(e1, e2);
    @(negedge clk);
    v1 = bus.rd_valid1; l1 = bus.lit_value1;
    v2 = bus.rd_valid2; l2 = bus.lit_value2;
    chk("addr_err", {31'd0, bus.addr_err}, {31'd0, err_m});
    chk("flip_count", bus.flip_count, CNT_EN ? fc_m : 32'd0);
    idle();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic lr, v1, l1, v2, l2, e1, e2;
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1,   1, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,   1, 0, 0, 0, 0};
    vecs[2]  = '{1, 7, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0,   1, 1, 1, 1, 1};
    vecs[3]  = '{1, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 1};
    vecs[4]  = '{1, 12, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 0, 1, 1, 0, 0};
    vecs[5]  = '{1, 12, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 3, 1, 1, 3, 0,   0, 0, 0, 0, 0};
    vecs[7]  = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,   1, 0, 0, 0, 0};
    vecs[9]  = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 1, 20, 0, 0, 0, 0, 1, 20, 1, 1, 0, 0, 1, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[12] = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 1};
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 0);
    chk("rst_load_ready", {31'd0, bus.load_ready}, 0);
    chk("rst_valid", {30'd0, bus.rd_valid1, bus.rd_valid2}, 0);
    chk("rst_lit", {30'd0, bus.lit_value1, bus.lit_value2}, 0);
    chk("rst_addr_err", {31'd0, bus.addr_err}, 0);
    chk("rst_flip_count", bus.flip_count, 0);
    rst = 1'b0;
    wait_ready(n);
    chk("clear_len", n, 2048);
    chk("ready_up", {31'd0, bus.ready}, 1);
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].r1, vecs[i].a1, vecs[i].n1, vecs[i].r2, vecs[i].a2, vecs[i].n2,
            vecs[i].w, vecs[i].fa, vecs[i].fv, vecs[i].lv, vecs[i].la, vecs[i].ld);
      run_cycle(lr, v1, l1, v2, l2, e1, e2);
      chk($sformatf("vec%0d_lr", i), {31'd0, lr}, vecs[i].x_lr);
      chk($sformatf("vec%0d_v1", i), {31'd0, v1}, vecs[i].x_v1);
      chk($sformatf("vec%0d_v2", i), {31'd0, v2}, vecs[i].x_v2);
      if (vecs[i].x_v1 != 0) chk($sformatf("vec%0d_l1", i), {31'd0, l1}, vecs[i].x_l1);
      if (vecs[i].x_v2 != 0) chk($sformatf("vec%0d_l2", i), {31'd0, l2}, vecs[i].x_l2);
    end
    chk("dir_addr_err", {31'd0, bus.addr_err}, 1);
    chk("dir_flip_count", bus.flip_count, CNT_EN ? 32'd2 : 32'd0);
    for (int i = 0; i < 400; i++) begin
      int r1, r2, w, lv, a1, a2, fa, la;
      r1 = int'($urandom_range(0, 1));
      r2 = int'($urandom_range(0, 1));
      w = int'($urandom_range(0, 9) < 3);
      lv = int'($urandom_range(0, 9) < 4);
      a1 = ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 31));
      fa = ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 31));
      la = ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 31));
      drive(r1, a1, int'($urandom_range(0, 1)), r2, a2, int'($urandom_range(0, 1)),
            w, fa, int'($urandom_range(0, 1)), lv, la, int'($urandom_range(0, 1)));
      run_cycle(lr, v1, l1, v2, l2, e1, e2);
      chk("rnd_lr", {31'd0, lr}, {31'd0, ~w[0]});
      chk("rnd_v1", {31'd0, v1}, r1);
      chk("rnd_v2", {31'd0, v2}, r2);
      if (r1 != 0) chk("rnd_l1", {31'd0, l1}, {31'd0, e1});
      if (r2 != 0) chk("rnd_l2", {31'd0, l2}, {31'd0, e2});
    end
    drive(1, 7, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, bus.rd_valid1}, 0);
    chk("mid_rst_ready", {31'd0, bus.ready}, 0);
    model_reset();
    rst = 1'b0;
    drive(1, 40, 0, 1, 41, 0, 1, 40, 1, 1, 41, 1);
    #1 chk("clear_load_ready", {31'd0, bus.load_ready}, 0);
    @(negedge clk);
    chk("clear_read_ignored", {30'd0, bus.rd_valid1, bus.rd_valid2}, 0);
    idle();
    wait_ready(n);
    chk("clear_len2", n + 1, 2048);
    chk("mid_rst_flip_count", bus.flip_count, 0);
    chk("mid_rst_addr_err", {31'd0, bus.addr_err}, 0);
    drive(1, 7, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(lr, v1, l1, v2, l2, e1, e2);
    chk("recl_7_12", {30'd0, v1, v2, l1, l2} >> 0, 32'b1100);
    drive(1, 20, 0, 1, 40, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(lr, v1, l1, v2, l2, e1, e2);
    chk("recl_20_40", {28'd0, v1, v2, l1, l2}, 32'b1100);
    drive(1, 41, 1, 1, 2047, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(lr, v1, l1, v2, l2, e1, e2);
    chk("recl_41_2047", {28'd0, v1, v2, l1, l2}, 32'b1110);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
